serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Parametrised multi-cycle unsigned subtractor computing diff = a - b with a borrow-out.
Processes BPC bits per clock, LSB first, through a chain of full-subtractor cells with a registered borrow between chunks.
Uses a start/busy/done handshake so that wide subtractions trade latency for area.
Used wherever the datapath needs a low-area WIDTH-bit subtract.

Parameters:
WIDTH, 8, operand and result width in bits.
BPC, 1, bits processed per cycle; WIDTH % BPC must be 0, otherwise elaboration fails.
NCHUNK, WIDTH/BPC, derived local constant giving the number of RUN cycles; not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  minuend; captured on the accepted start.
b  input  WIDTH  subtrahend; captured on the accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; results are valid from this cycle on.
diff  output  WIDTH  registered result; holds until the next completion.
borrow_out  output  1  final borrow, 1 when a < b; held with diff.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- All state is registered. No combinational path from inputs to outputs.
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE
  - busy=0, done=0, diff=0, borrow_out=0
  - internal shift registers and borrow cleared
  - rst dominates start.
- FSM states:
  - IDLE: start=1 loads a and b into shift registers, clears borrow and chunk counter, goes to RUN.
  - RUN: busy=1. Each edge:
    - cell chain computes the low BPC bits of sa - sb - borrow
    - result chunk shifts into the result register from the MSB side
    - sa and sb shift right by BPC
    - borrow updates and the counter increments
    - after the NCHUNK-th RUN edge: diff, borrow_out loaded; go to DONE.
  - DONE: done=1, busy=0, lasts exactly one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back, no bubble).
    - otherwise go to IDLE.
- Latency: done is high in the cycle that starts NCHUNK+1 edges after the edge that sampled start. BPC=WIDTH gives 2 edges.
- start while busy=1 is ignored and has no effect on operands or results.
- a and b may change freely after the accepted start.
- Arithmetic: full-subtractor cell per bit.
  - d = x ^ y ^ bin
  - bout = (~x & y) | (~(x ^ y) & bin)
  - Chunk 0 has bin=0. Result wraps modulo 2^WIDTH.
- diff and borrow_out change only at completion or reset. Between operations they hold the last result.
- Reset mid-RUN aborts the operation: no done pulse, outputs zeroed.

Optional Feature:
Macro SERIAL_SUBTRACTOR_CLAMP_EN.
- Defined: when the final borrow is 1, diff is loaded as 0 (unsigned saturation). borrow_out still reports 1.
- Undefined: diff is the wrapped modulo-2^WIDTH result.
- Latency is identical in both builds.

Decomposition:
- Package serial_subtractor_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE)
  - the counter-width function clog2(NCHUNK) (minimum width 1)
  - the WIDTH % BPC legality check constant.
- Sub-module full_subtractor (x, y, bin -> d, bout), instantiated BPC times in a generate loop. Top holds the FSM, counter and registers.

Test Plan:
- WIDTH=8, BPC=1, a=0x5A, b=0x3C, pulse start -> busy high 8 cycles; done on the 9th edge; diff=0x1E, borrow_out=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. With SERIAL_SUBTRACTOR_CLAMP_EN: diff=0x00, borrow_out=1.
- Start accepted with a=0x10, b=0x01, then start re-pulsed mid-RUN with a=0xFF, b=0x00 -> ignored; done once, diff=0x0F. Then start held high through DONE with a=0x03, b=0x05 -> next op runs with no idle cycle; diff=0xFE, borrow_out=1.
- rst asserted on RUN cycle 4 -> next cycle state=IDLE, busy=0, diff=0, borrow_out=0, no done pulse. A fresh start afterwards completes normally.
- WIDTH=4, BPC=2 and BPC=4: exhaustive 256 operand pairs vs reference model -> diff=(a-b) mod 16, borrow_out=(a<b); latencies 3 and 2 edges respectively.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
// Holds the FSM state encoding, counter sizing and the WIDTH/BPC legality check.
// Optional build macro used by the top: SERIAL_SUBTRACTOR_CLAMP_EN (unsigned saturation).
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1 chunks, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // The operand must split into an integral number of BPC-bit chunks.
    function automatic bit chunk_legal(input int width, input int bpc);
        return (bpc > 0) && (width > 0) && (bpc <= width) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, bout is the borrow to the next bit.
// Purely combinational, zero latency.
// No handshake; the enclosing chain decides when results are captured.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b, BPC bits per clock, LSB first, borrow_out = (a < b).
// Latency: busy for NCHUNK cycles after the accepted start, then a one-cycle done pulse.
// Backpressure: start is ignored while busy; accepted in IDLE or DONE (back-to-back in DONE).
// Build option: define SERIAL_SUBTRACTOR_CLAMP_EN to saturate diff at 0 when the result borrows.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int NCHUNK = WIDTH / BPC;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    generate
        if (!chunk_legal(WIDTH, BPC)) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be a positive multiple of BPC");
        end
    endgenerate

    state_t           state;
    state_t           nxt_state;
    logic             load_op;
    logic             finish_op;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_q;
    logic [CW-1:0]    cnt;

    logic [BPC-1:0]   chunk_d;
    logic [BPC:0]     bchain;
    logic [WIDTH-1:0] res_next;

    // Borrow ripples through the chunk from the registered borrow of the previous chunk.
    assign bchain[0] = borrow_q;

    genvar gi;
    generate
        for (gi = 0; gi < BPC; gi++) begin : g_cell
            full_subtractor u_fs (
                .x    (sa[gi]),
                .y    (sb[gi]),
                .bin  (bchain[gi]),
                .d    (chunk_d[gi]),
                .bout (bchain[gi+1])
            );
        end
    endgenerate

    // New chunk enters from the MSB side so that after NCHUNK shifts chunk 0 sits at the LSBs.
    assign res_next = (res_sr >> BPC) | (WIDTH'(chunk_d) << (WIDTH - BPC));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state decode and status outputs; busy/done depend on registered state only.
    always_comb begin
        nxt_state = state;
        busy      = 1'b0;
        done      = 1'b0;
        load_op   = 1'b0;
        finish_op = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_op   = 1'b1;
                    nxt_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    finish_op = 1'b1;
                    nxt_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load_op   = 1'b1;
                    nxt_state = RUN;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Operand shifters, chunk counter and running borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (load_op) begin
            sa       <= a;
            sb       <= b;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (state == RUN) begin
            sa       <= sa >> BPC;
            sb       <= sb >> BPC;
            res_sr   <= res_next;
            borrow_q <= bchain[BPC];
            cnt      <= cnt + 1'b1;
        end
    end

    // Result registers only move at completion, so they hold between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (finish_op) begin
            borrow_out <= bchain[BPC];
`ifdef SERIAL_SUBTRACTOR_CLAMP_EN
            diff       <= bchain[BPC] ? '0 : res_next;
`else
            diff       <= res_next;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three instances (8/1, 4/2, 4/4).
// Inputs driven and outputs sampled on the falling clock edge.
// Expected values come from plain modular arithmetic on the operands.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bo8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy42, done42, bo42;
    logic [3:0] diff42;
    logic       busy44, done44, bo44;
    logic [3:0] diff44;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .BPC(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(4), .BPC(2)) dut42 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy42), .done(done42), .diff(diff42), .borrow_out(bo42)
    );

    serial_subtractor #(.WIDTH(4), .BPC(4)) dut44 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy44), .done(done44), .diff(diff44), .borrow_out(bo44)
    );

    // Reference: unsigned subtraction modulo 2^w, optionally saturated at zero.
    function automatic logic [7:0] ref_diff(input int w, input int unsigned x, input int unsigned y);
        int unsigned m;
        int unsigned r;
        m = 1 << w;
        r = (x + m - y) % m;
`ifdef SERIAL_SUBTRACTOR_CLAMP_EN
        if (x < y) r = 0;
`endif
        return 8'(r);
    endfunction

    function automatic logic ref_borrow(input int unsigned x, input int unsigned y);
        return x < y;
    endfunction

    // Starts one 8-bit operation from a falling edge and waits for done.
    // lat counts rising edges from the sampling edge to the done cycle.
    task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input bit scramble,
                        output int lat, output int busy_cycles);
        a8 = xa;
        b8 = xb;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cycles++;
            if (scramble) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check8(input string name, input logic [7:0] xa, input logic [7:0] xb, input int lat);
        logic [7:0] ed;
        logic       eb;
        ed = ref_diff(8, xa, xb);
        eb = ref_borrow(xa, xb);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want 9", name, lat);
        end
        checks++;
        if (diff8 !== ed) begin
            errors++;
            $display("FAIL %s diff (%h-%h): got %h, want %h", name, xa, xb, diff8, ed);
        end
        checks++;
        if (bo8 !== eb) begin
            errors++;
            $display("FAIL %s borrow_out (%h-%h): got %b, want %b", name, xa, xb, bo8, eb);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start8 = 1'b1;
        start4 = 1'b1;
        a8 = 8'hA5; b8 = 8'h11; a4 = 4'h9; b4 = 4'h2;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, diff8, bo8} !== 11'b0) begin
            errors++;
            $display("FAIL reset dut8: busy=%b done=%b diff=%h bo=%b, want all 0", busy8, done8, diff8, bo8);
        end
        checks++;
        if ({busy42, done42, diff42, bo42, busy44, done44, diff44, bo44} !== 14'b0) begin
            errors++;
            $display("FAIL reset dut4: outputs %b, want all 0",
                     {busy42, done42, diff42, bo42, busy44, done44, diff44, bo44});
        end
        start8 = 1'b0;
        start4 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy: got %b, want 0", busy8);
        end
    endtask

    task automatic test_basic;
        int lat, bc;
        run8(8'h5A, 8'h3C, 1'b0, lat, bc);
        check8("basic", 8'h5A, 8'h3C, lat);
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic busy_cycles: got %0d, want 8", bc);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL basic busy_at_done: got %b, want 0", busy8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || diff8 !== ref_diff(8, 8'h5A, 8'h3C)) begin
            errors++;
            $display("FAIL basic hold: done=%b diff=%h, want done=0 diff=%h", done8, diff8, ref_diff(8, 8'h5A, 8'h3C));
        end
    endtask

    task automatic test_edges;
        logic [15:0] tbl [6];
        int lat, bc;
        tbl = '{16'h0001, 16'hFFFF, 16'h00FF, 16'hFF00, 16'h807F, 16'h7F80};
        foreach (tbl[i]) begin
            run8(tbl[i][15:8], tbl[i][7:0], 1'b1, lat, bc);
            check8("edge", tbl[i][15:8], tbl[i][7:0], lat);
            @(negedge clk);
        end
    endtask

    task automatic test_random8;
        logic [7:0] xa, xb;
        int lat, bc;
        for (int i = 0; i < 16; i++) begin
            xa = 8'($urandom);
            xb = 8'($urandom);
            run8(xa, xb, 1'b1, lat, bc);
            check8("random8", xa, xb, lat);
            if (i % 2 == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        @(negedge clk); n++;
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk); n++;
        start8 = 1'b0;
        @(negedge clk); n++;
        a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check8("ignore_start", 8'h10, 8'h01, n);
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back no_bubble: busy=%b done=%b, want busy=1 done=0", busy8, done8);
        end
        n = 1;
        while (!done8 && n < 40) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check8("back_to_back", 8'h03, 8'h05, n);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones;
        int lat, bc;
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, diff8, bo8} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h bo=%b, want all 0", busy8, done8, diff8, bo8);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid done_pulses: got %0d, want 0", dones);
        end
        run8(8'h81, 8'h02, 1'b1, lat, bc);
        check8("after_reset", 8'h81, 8'h02, lat);
        @(negedge clk);
    endtask

    task automatic test_exhaustive4;
        int n, lat2, lat4;
        logic [3:0] d2, d4;
        logic b2, b4v;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a4 = 4'(x);
                b4 = 4'(y);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                n = 1; lat2 = 0; lat4 = 0;
                d2 = 'x; d4 = 'x; b2 = 1'bx; b4v = 1'bx;
                while ((lat2 == 0 || lat4 == 0) && n < 20) begin
                    if (done42 && lat2 == 0) begin lat2 = n; d2 = diff42; b2 = bo42; end
                    if (done44 && lat4 == 0) begin lat4 = n; d4 = diff44; b4v = bo44; end
                    a4 = 4'($urandom);
                    b4 = 4'($urandom);
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (lat2 !== 3 || lat4 !== 2) begin
                    errors++;
                    $display("FAIL exh4 latency (%0d-%0d): got %0d/%0d, want 3/2", x, y, lat2, lat4);
                end
                checks++;
                if (d2 !== ref_diff(4, x, y) || b2 !== ref_borrow(x, y)) begin
                    errors++;
                    $display("FAIL exh4 bpc2 (%0d-%0d): got diff=%h bo=%b, want diff=%h bo=%b",
                             x, y, d2, b2, ref_diff(4, x, y), ref_borrow(x, y));
                end
                checks++;
                if (d4 !== ref_diff(4, x, y) || b4v !== ref_borrow(x, y)) begin
                    errors++;
                    $display("FAIL exh4 bpc4 (%0d-%0d): got diff=%h bo=%b, want diff=%h bo=%b",
                             x, y, d4, b4v, ref_diff(4, x, y), ref_borrow(x, y));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_edges();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_exhaustive4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
